key_input_ctrl: RTL



---
 rtl/key_pkg.sv | 15 +
 rtl/key_debounce_ch.sv | 120 ++++++++++++
 rtl/key_input_ctrl.sv | 43 ++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and default timing constants for the pushbutton input controller.
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } key_state_t;

    // 20 ms debounce and 0.5 s auto-repeat at 50 MHz
    localparam int KEY_DEBOUNCE_50M = 1_000_000;
    localparam int KEY_HOLD_50M     = 25_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, hold/auto-repeat counter
// and registered level/press/release/hold outputs.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_50M,
    parameter int HOLD_CYCLES     = KEY_HOLD_50M,
    parameter int CNT_W           = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_hold
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    logic [1:0]       sync_reg;
    key_state_t       state_reg, state_next;
    logic [CNT_W-1:0] dcnt_reg, dcnt_next;
    logic [CNT_W-1:0] hcnt_reg, hcnt_next;
    logic             level_reg, level_next;
    logic             press_reg, press_next;
    logic             release_reg, release_next;
    logic             hold_reg, hold_next;
    logic             p;

    // Synchroniser idles at 1 so a reset never looks like a press
    assign p = ~sync_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= 2'b11;
            state_reg   <= RELEASED;
            dcnt_reg    <= CNT_ZERO;
            hcnt_reg    <= CNT_ZERO;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            hold_reg    <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], key_n};
            state_reg   <= state_next;
            dcnt_reg    <= dcnt_next;
            hcnt_reg    <= hcnt_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            hold_reg    <= hold_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        dcnt_next    = dcnt_reg;
        hcnt_next    = hcnt_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        hold_next    = 1'b0;

        case (state_reg)
            RELEASED: begin
                if (p) begin
                    state_next = PRESS_CHK;
                    dcnt_next  = CNT_ZERO;
                end
            end
            PRESS_CHK: begin
                if (!p) begin
                    state_next = RELEASED;
                end else if (dcnt_reg == DB_LAST) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                    hcnt_next  = CNT_ZERO;
                end else begin
                    dcnt_next = dcnt_reg + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!p) begin
                    state_next = RELEASE_CHK;
                    dcnt_next  = CNT_ZERO;
                end else if (hcnt_reg == HOLD_LAST) begin
                    hold_next = 1'b1;
                    hcnt_next = CNT_ZERO;
                end else begin
                    hcnt_next = hcnt_reg + CNT_ONE;
                end
            end
            RELEASE_CHK: begin
                // hcnt stays frozen so a release bounce does not restart the repeat period
                if (p) begin
                    state_next = PRESSED;
                end else if (dcnt_reg == DB_LAST) begin
                    state_next   = RELEASED;
                    release_next = 1'b1;
                end else begin
                    dcnt_next = dcnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = RELEASED;
            end
        endcase

        level_next = (state_next == PRESSED) || (state_next == RELEASE_CHK);
    end

    assign key_level   = level_reg;
    assign key_press   = press_reg;
    assign key_release = release_reg;
    assign key_hold    = hold_reg;

endmodule

// File: rtl/key_input_ctrl.sv
// Debounced pushbutton controller: N_KEYS independent channels plus an
// any-press summary for the command logic.
module key_input_ctrl
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_50M,
    parameter int HOLD_CYCLES     = KEY_HOLD_50M,
    parameter int CNT_W           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keys_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_hold,
    output logic              any_press
);

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_ch
            key_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .HOLD_CYCLES     (HOLD_CYCLES),
                .CNT_W           (CNT_W)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .key_n       (keys_n[gi]),
                .key_level   (key_level[gi]),
                .key_press   (key_press[gi]),
                .key_release (key_release[gi]),
                .key_hold    (key_hold[gi])
            );
        end
    endgenerate

    // OR of registered pulses, so still no path from keys_n
    assign any_press = |key_press;

endmodule
